prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter.sv | 68 ++++++
 tb/tb_prog_counter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// prog_counter: up/down counter with range 0..limit, wrap or saturate, one-shot and load,
// sequenced by an IDLE/RUN/DONE state machine with registered outputs.
module prog_counter #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d, next_val;
    logic tc_q, tc_d, busy_q, busy_d, done_q, done_d;
    logic over, term;
    always_comb begin
        over = count_q > limit;
        // an up-step from an out-of-range count counts as reaching the terminal value
        term = up_dn ? count_q >= limit : count_q == '0;
        next_val = up_dn ? (term ? (sat ? limit : '0) : count_q + 1'b1)
                         : (over ? limit : term ? (sat ? '0 : limit) : count_q - 1'b1);
        count_d = count_q;
        tc_d = 1'b0;
        state_d = state_q;
        if (load) begin
            count_d = load_val > limit ? limit : load_val;
            state_d = (state_q == RUN || start) ? RUN : IDLE;
        end else if (state_q != RUN) begin
            state_d = start ? RUN : state_q;
        end else if (en) begin
            count_d = next_val;
            tc_d = term;
            state_d = (term && oneshot) ? DONE : RUN;
        end
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= RESET_VAL;
            tc_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q <= tc_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign count = count_q;
    assign tc = tc_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed and random stimulus; a reference model queues expected outputs
// per cycle and an independent monitor pops and compares them after each rising edge.
module tb_prog_counter;
    localparam int RV = 3;
    typedef struct packed {
        logic [7:0] c;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, en = 1'b0, up_dn = 1'b1, load = 1'b0, sat = 1'b0, oneshot = 1'b0;
    logic [7:0] load_val = '0, limit = '0;
    logic [7:0] count;
    logic tc, busy, done;
    exp_t q[$];
    int checks = 0, errors = 0;
    int m_count = 0;
    bit m_run = 0, m_done = 0;

    prog_counter #(.WIDTH(8), .RESET_VAL(8'(RV))) dut (
        .clk(clk), .reset(reset), .start(start), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .limit(limit), .sat(sat), .oneshot(oneshot),
        .count(count), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc(input bit r, input bit s, input bit e, input bit ud, input bit ld,
                       input int lv, input int lim, input bit sa, input bit os);
        bit t;
        exp_t x;
        @(negedge clk);
        reset = r; start = s; en = e; up_dn = ud; load = ld;
        load_val = 8'(lv); limit = 8'(lim); sat = sa; oneshot = os;
        t = 0;
        if (r) begin
            m_count = RV; m_run = 0; m_done = 0;
        end else if (ld) begin
            m_count = (lv < lim) ? lv : lim;
            m_run = m_run || s;
            m_done = 0;
        end else if (!m_run) begin
            if (s) begin m_run = 1; m_done = 0; end
        end else if (e) begin
            if (ud) begin
                t = m_count >= lim;
                m_count = t ? (sa ? lim : 0) : m_count + 1;
            end else if (m_count > lim) begin
                m_count = lim;
            end else begin
                t = m_count == 0;
                m_count = t ? (sa ? 0 : lim) : m_count - 1;
            end
            if (t && os) begin m_run = 0; m_done = 1; end
        end
        x.c = 8'(m_count); x.tc = t; x.busy = m_run; x.done = m_done;
        q.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                exp_t x;
                x = q.pop_front();
                checks++;
                if (count !== x.c || tc !== x.tc || busy !== x.busy || done !== x.done) begin
                    errors++;
                    $display("FAIL cycle_check t=%0t got count=%0d tc=%0b busy=%0b done=%0b expected count=%0d tc=%0b busy=%0b done=%0b",
                             $time, count, tc, busy, done, x.c, x.tc, x.busy, x.done);
                end
            end
        end
    end

    initial begin
        int lim;
        cyc(1, 0, 0, 1, 0, 0, 5, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 5, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 5, 0, 0);
        // wrap up: load 0 and start together, then 8 up-steps
        cyc(0, 1, 0, 1, 1, 0, 5, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0, 0, 5, 0, 0);
        // saturate down from 3
        cyc(0, 0, 1, 0, 1, 3, 5, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0, 5, 1, 0);
        // one-shot, then restart
        cyc(1, 0, 0, 1, 0, 0, 2, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 2, 0, 1);
        cyc(0, 1, 0, 1, 0, 0, 2, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0, 2, 0, 1);
        cyc(0, 1, 0, 1, 0, 0, 2, 0, 1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 1, 0, 0, 2, 0, 1);
        // load clamp and priority, then reach DONE, then load back to IDLE
        cyc(0, 0, 1, 1, 1, 200, 10, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 10, 0, 1);
        cyc(0, 0, 1, 1, 0, 0, 10, 0, 1);
        cyc(0, 0, 1, 1, 1, 7, 10, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 10, 0, 0);
        // lowered limit, wrap then saturate
        cyc(0, 1, 0, 1, 1, 9, 10, 0, 0);
        cyc(0, 0, 1, 1, 0, 0, 4, 0, 0);
        cyc(0, 0, 1, 1, 1, 9, 10, 1, 0);
        cyc(0, 0, 1, 1, 0, 0, 4, 1, 0);
        cyc(0, 0, 1, 0, 1, 9, 10, 1, 0);
        cyc(0, 0, 1, 0, 0, 0, 4, 1, 0);
        // reset on a terminal-event cycle
        cyc(0, 0, 0, 1, 1, 5, 5, 0, 0);
        cyc(1, 0, 1, 1, 0, 0, 5, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 5, 0, 0);
        // limit 0
        cyc(0, 1, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, i % 2 == 0, 0, 0, 0, i == 1, 0);
        lim = 6;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0)
                lim = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0,
                ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 14),
                lim, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
